// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order post-retirement store FIFO. Accepts retired
// stores from the LSQ, drains them to data memory over a req/ack handshake
// with generated byte enables, and answers combinational load-forwarding
// queries against the buffered stores.
// Optional feature macro: STORE_COMMIT_FWD_EN (defined = full data forwarding;
// undefined = loads that touch buffered bytes only stall until drained).
module store_commit_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_wb,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        st_sh,
  input  logic [4:0]  st_rob_tag,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_be,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [4:0]  tag;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  entry_t             w_new;
  logic               w_push;
  logic               w_pop;
  logic [DEPTH-1:0]   w_slot_match;
  logic [5:0]         w_unused_bits;

  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);
  assign overflow = r_overflow;

  // A pop frees the head slot this edge, so a push at full is still accepted.
  assign w_pop  = mem_ack && !empty;
  assign w_push = store_wb && (!full || w_pop);

  // Store and debug-tag bits that do not feed any datapath.
  assign w_unused_bits = {st_addr[0], r_mem[r_head].tag};

  // Lane-align the incoming store and build its byte enables.
  always_comb begin
    w_new.waddr = st_addr[31:2];
    w_new.tag   = st_rob_tag;
    w_new.be    = 4'b1111;
    w_new.data  = st_data;
    if (st_sh) begin
      if (st_addr[1]) begin
        w_new.be   = 4'b1100;
        w_new.data = {st_data[15:0], 16'h0000};
      end else begin
        w_new.be   = 4'b0011;
        w_new.data = {16'h0000, st_data[15:0]};
      end
    end
  end

  // Entry payload storage, written at the tail on an accepted push.
  // NOTE: the payload array has no reset; the valid bits alone decide whether
  // a slot is live, and all consumers gate on them or on the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_new;
  end

  // Pointers, count, valid bits and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Push is applied after pop so a full-buffer push/pop into the same
      // slot leaves it valid.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (store_wb && full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Present the head entry to memory; outputs read zero when nothing is held.
  always_comb begin
    mem_req   = !empty;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (!empty) begin
      mem_addr  = {r_mem[r_head].waddr, 2'b00};
      mem_wdata = r_mem[r_head].data;
      mem_be    = r_mem[r_head].be;
    end
  end

  // Per-slot overlap between the load query and each live entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_match[i] = r_valid[i] && (r_mem[i].waddr == ld_addr[31:2]) &&
                        ((r_mem[i].be & ld_be) != 4'b0000);
    end
  end

`ifdef STORE_COMMIT_FWD_EN
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_sel;
  logic             w_any_match;

  // Walk oldest to youngest so the youngest match wins, then forward or stall.
  always_comb begin
    w_idx       = '0;
    w_sel       = '0;
    w_any_match = 1'b0;
    ld_hit      = 1'b0;
    ld_stall    = 1'b0;
    ld_data     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (w_slot_match[w_idx]) begin
        w_any_match = 1'b1;
        w_sel       = w_idx;
      end
    end
    if (ld_valid && w_any_match) begin
      if ((r_mem[w_sel].be & ld_be) == ld_be) begin
        ld_hit  = 1'b1;
        ld_data = r_mem[w_sel].data;
      end else begin
        ld_stall = 1'b1;
      end
    end
  end
`else
  // Without forwarding, any overlap with buffered data holds the load.
  always_comb begin
    ld_hit   = 1'b0;
    ld_data  = '0;
    ld_stall = ld_valid && (|w_slot_match);
  end
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios plus
// randomized traffic, compared against a queue-based reference model.
module tb_store_commit_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        store_wb;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_sh;
  logic [4:0]  st_rob_tag;
  logic        full, empty, overflow, mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;

  store_commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .store_wb(store_wb), .st_addr(st_addr),
    .st_data(st_data), .st_sh(st_sh), .st_rob_tag(st_rob_tag),
    .full(full), .empty(empty), .overflow(overflow), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_be(ld_be), .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the buffer is an ordered list of {word, be, data}.
  typedef struct {
    logic [29:0] w;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_ovf = 1'b0;

  function automatic ent_t make_ent(logic [31:0] a, logic [31:0] d, logic sh);
    ent_t e;
    e.w = a[31:2];
    if (!sh)        begin e.be = 4'hF; e.d = d; end
    else if (a[1])  begin e.be = 4'hC; e.d = {d[15:0], 16'h0}; end
    else            begin e.be = 4'h3; e.d = {16'h0, d[15:0]}; end
    return e;
  endfunction

  task automatic model_fwd(input logic lv, input logic [31:0] la, input logic [3:0] lbe,
                           output logic hit, output logic stall, output logic [31:0] data);
    hit = 1'b0; stall = 1'b0; data = '0;
    if (lv) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].w == la[31:2] && (q[i].be & lbe) != 4'h0) begin
`ifdef STORE_COMMIT_FWD_EN
          if ((q[i].be & lbe) == lbe) begin hit = 1'b1; data = q[i].d; end
          else stall = 1'b1;
`else
          stall = 1'b1;
`endif
          break;
        end
      end
    end
  endtask

  // Compare every output against the model state.
  task automatic check_all();
    logic eh, es;
    logic [31:0] ed;
    check("empty",    32'(empty),    32'(q.size() == 0));
    check("full",     32'(full),     32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("mem_req",  32'(mem_req),  32'(q.size() != 0));
    check("mem_addr",  mem_addr,  q.size() ? {q[0].w, 2'b00} : 32'h0);
    check("mem_wdata", mem_wdata, q.size() ? q[0].d : 32'h0);
    check("mem_be",    32'(mem_be), q.size() ? 32'(q[0].be) : 32'h0);
    model_fwd(ld_valid, ld_addr, ld_be, eh, es, ed);
    check("ld_hit",   32'(ld_hit),   32'(eh));
    check("ld_stall", 32'(ld_stall), 32'(es));
    check("ld_data",  ld_data, ed);
  endtask

  // One clock: drive at negedge, check before the edge, update the model after.
  task automatic step(input logic wb, input logic [31:0] a, input logic [31:0] d,
                      input logic sh, input logic ack, input logic lv,
                      input logic [31:0] la, input logic [3:0] lbe);
    bit pop, push;
    ent_t e;
    store_wb = wb; st_addr = a; st_data = d; st_sh = sh;
    st_rob_tag = 5'($urandom); mem_ack = ack;
    ld_valid = lv; ld_addr = la; ld_be = lbe;
    #1;
    check_all();
    pop  = ack && q.size() != 0;
    push = wb && (q.size() < DEPTH || pop);
    if (wb && q.size() == DEPTH && !pop) m_ovf = 1'b1;
    e = make_ent(a, d, sh);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic push_sw(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic drain();
    for (int i = 0; i <= DEPTH; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
  endtask

  initial begin
    reset = 1'b0; store_wb = 0; st_addr = 0; st_data = 0; st_sh = 0; st_rob_tag = 0;
    mem_ack = 0; ld_valid = 0; ld_addr = 0; ld_be = 0;
    #3;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // sh to upper half: lane-aligned data and byte enables.
    step(1'b1, 32'h0000_1002, 32'hAAAA_1234, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    check("sh_req",   32'(mem_req), 32'h1);
    check("sh_addr",  mem_addr, 32'h0000_1000);
    check("sh_be",    32'(mem_be), 32'hC);
    check("sh_wdata", mem_wdata, 32'h1234_0000);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
    check("sh_drained", 32'(empty), 32'h1);

    // Fill, overflow, push+pop at full, then in-order drain.
    for (int i = 0; i < DEPTH; i++) push_sw(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    check("fill_full", 32'(full), 32'h1);
    push_sw(32'h0000_0020, 32'hDEAD_BEEF);
    check("ovf_set", 32'(overflow), 32'h1);
    step(1'b1, 32'h0000_0024, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
    check("pp_full", 32'(full), 32'h1);
    check("pp_head", mem_addr, 32'h0000_0014);
    drain();
    check("drain_empty", 32'(empty), 32'h1);

    // Youngest-match forwarding.
    push_sw(32'h20, 32'h1111_1111);
    push_sw(32'h20, 32'h2222_2222);
    ld_valid = 1'b1; ld_addr = 32'h20; ld_be = 4'hF;
    #1;
`ifdef STORE_COMMIT_FWD_EN
    check("young_hit",  32'(ld_hit), 32'h1);
    check("young_data", ld_data, 32'h2222_2222);
`else
    check("young_stall", 32'(ld_stall), 32'h1);
    check("young_hit",   32'(ld_hit), 32'h0);
`endif
    drain();

    // Partial overlap with a buffered halfword.
    step(1'b1, 32'h30, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    ld_valid = 1'b1; ld_addr = 32'h30; ld_be = 4'hF;
    #1;
    check("part_stall", 32'(ld_stall), 32'h1);
    check("part_hit",   32'(ld_hit), 32'h0);
    ld_be = 4'h3;
    #1;
`ifdef STORE_COMMIT_FWD_EN
    check("low_hit",  32'(ld_hit), 32'h1);
    check("low_data", ld_data, 32'h0000_BEEF);
`else
    check("low_stall", 32'(ld_stall), 32'h1);
    check("low_hit",   32'(ld_hit), 32'h0);
`endif
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h32, 4'h3);
    drain();

    // Randomized traffic over a small word pool so matches are frequent.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0),
           32'h40 + 32'($urandom_range(0, 15)), $urandom, 1'($urandom),
           1'($urandom_range(0, 2) == 0),
           1'($urandom), 32'h40 + 32'($urandom_range(0, 15)), 4'($urandom));
    end

    // Asynchronous reset with three entries held and overflow set.
    drain();
    if (!m_ovf) begin
      for (int i = 0; i <= DEPTH; i++) push_sw(32'h50, 32'h0);
      drain();
    end
    for (int i = 0; i < 3; i++) push_sw(32'h60 + 32'(4 * i), 32'h7700_0000 + 32'(i));
    check("pre_rst_req", 32'(mem_req), 32'h1);
    #2;
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_req",   32'(mem_req), 32'h0);
    check("rst_ovf",   32'(overflow), 32'h0);
    check("rst_addr",  mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 50; n++) begin
      step(1'($urandom), 32'h40 + 32'($urandom_range(0, 15)), $urandom, 1'($urandom),
           1'($urandom), 1'($urandom), 32'h40 + 32'($urandom_range(0, 15)), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

Post-retirement store buffer sitting directly downstream of the load/store queue. It accepts each retired store that the LSQ emits on its store write-back strobe and holds it in a small in-order FIFO. It drains the stores to the data memory through a request/acknowledge handshake, generating the memory byte enables. It also answers same-cycle forwarding queries from the load path, so loads never read stale memory.

## Interface
- DEPTH, default 4: number of buffered stores; must be a power of two, at least 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; a low level clears all state immediately.
- store_wb  input  1  push strobe from the LSQ; one retired store per cycle.
- st_addr  input  32  byte address of the store, already computed by the LSQ.
- st_data  input  32  store data, register value; only the low half is used for sh.
- st_sh  input  1  store size; 0 = sw, 1 = sh.
- st_rob_tag  input  5  ROB tag of the store, kept for debug and trace only.
- full  output  1  count == DEPTH; the ROB must not retire a store while this is high.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag, set when a push arrives while full.
- mem_req  output  1  head entry valid and presented to memory.
- mem_addr  output  32  head address with bits [1:0] forced to 00.
- mem_wdata  output  32  head data, lane-aligned.
- mem_be  output  4  head byte enables.
- mem_ack  input  1  memory accepted the head write this cycle.
- ld_valid  input  1  load forwarding query is active.
- ld_addr  input  32  load word address; bits [1:0] are ignored.
- ld_be  input  4  bytes the load needs.
- ld_hit  output  1  the youngest matching entry fully covers ld_be.
- ld_data  output  32  forwarded word, lane-aligned; valid only when ld_hit = 1.
- ld_stall  output  1  the load overlaps buffered data that cannot be forwarded.

## Operation
- **Enqueue.** When store_wb = 1 and full = 0, write the entry at the tail {addr[31:2], be, lane data, rob_tag} and advance the tail.
  - sw: be = 1111, data passed through unchanged.
  - sh with addr[1] = 0: be = 0011, data = {16'b0, st_data[15:0]}.
  - sh with addr[1] = 1: be = 1100, data = {st_data[15:0], 16'b0}.
  - st_addr[0] is ignored; the LSQ guarantees alignment.
- **Push while full.** The store is dropped, state is unchanged, and overflow is set. overflow stays set until reset.
- **Drain.**
  - mem_req = !empty.
  - mem_addr, mem_wdata and mem_be come from the head entry and are registered from the entry storage, not from the inputs.
  - The head stays stable until mem_ack = 1, then pops.
  - mem_ack while empty is ignored.
- **Simultaneous push and pop.** Both take effect and the count is unchanged. This is legal even when full = 1, because the pop frees a slot in the same cycle and the push is accepted.
- **Pointers.** Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- **Forwarding (combinational).** An entry "matches" when it is valid, its addr[31:2] equals ld_addr[31:2], and (entry be & ld_be) != 0. Only the youngest matching entry (the one closest to the tail) is considered.
  - If that entry's be covers all of ld_be: ld_hit = 1, ld_data = entry data, ld_stall = 0.
  - If it does not fully cover ld_be: ld_hit = 0, ld_stall = 1.
  - No match, or ld_valid = 0: ld_hit = 0, ld_stall = 0, ld_data = 0.
- **Head being acked.** A head entry that receives mem_ack in the same cycle still participates in forwarding.
- **Same-cycle push.** A store being pushed in the same cycle is not visible to the query.

## Timing
- **Reset values.** All entries invalid; head = 0, tail = 0, count = 0; empty = 1, full = 0, overflow = 0, mem_req = 0; mem_addr, mem_wdata and mem_be = 0; ld_hit = 0, ld_stall = 0, ld_data = 0.
- **Push to request latency.** A push into an empty buffer at edge N gives mem_req = 1 after edge N.
- **Back-to-back drain.** With mem_ack held high, the buffer drains one store per cycle. The next head appears on the edge after each ack.
- **Status flags.** full and empty reflect the count after the edge; they are not combinational on store_wb.
- **Forwarding latency.** Forwarding outputs settle in the same cycle as ld_valid and ld_addr, with zero latency.
- **Reset mid-transfer.** Asserting reset while mem_req = 1 discards every buffered store. This is allowed only with the memory idle.

## Configuration
- `STORE_COMMIT_FWD_EN` defined: forwarding works as described above.
- `STORE_COMMIT_FWD_EN` undefined:
  - ld_hit and ld_data are tied to 0.
  - ld_stall = 1 whenever any valid entry matches. Loads then wait for the drain.
  - The youngest-match priority logic is removed.

## Test plan
- **sh byte enables.** After reset, push sh with addr 0x0000_1002 and data 0xAAAA_1234, then ack. Expect mem_req one cycle later, mem_addr 0x1000, mem_be 1100, mem_wdata 0x1234_0000.
- **Fill and drain.** Push 4 sw to addresses 0x10 through 0x1C with mem_ack = 0. Expect full = 1. A fifth push sets overflow = 1 and is dropped. Then hold ack high: expect 4 writes in order on 4 consecutive cycles, then empty = 1.
- **Push and pop at full.** With full = 1, assert store_wb and mem_ack in the same cycle. Expect the count unchanged, the new entry at the wrapped tail, and it drained last.
- **Youngest-match forwarding.** Push sw 0x20 = 0x1111_1111, then sw 0x20 = 0x2222_2222. Query ld_addr 0x20 with ld_be 1111: expect ld_hit = 1 and ld_data 0x2222_2222.
- **Partial overlap.** Push sh 0x30 = 0xBEEF. Query with ld_be 1111: expect ld_stall = 1 and ld_hit = 0. Query with ld_be 0011: expect ld_hit = 1 and ld_data 0x0000_BEEF. With `STORE_COMMIT_FWD_EN` undefined, both queries give ld_stall = 1.
- **Async reset.** Pull reset low mid-cycle with 3 entries buffered. Expect empty = 1, mem_req = 0 and overflow = 0 immediately, without waiting for a clock edge.
